if_prefetch_stage: RTL and testbench

- Parametrised successor to the single-PC fetch stage.
- Owns the PC and issues pipelined instruction-memory requests with variable response latency.
- Buffers returned instructions with their PCs in a DEPTH-entry prefetch FIFO and hands them to decode over a valid/ready handshake.
- Branch/jump resolution logic upstream supplies a single redirect pulse plus target. This block flushes the FIFO and discards stale in-flight responses.

---
 rtl/if_prefetch_stage.sv | 168 ++++++++++++++++
 tb/tb_if_prefetch_stage.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_prefetch_stage.sv
// Instruction-fetch prefetch stage. It owns the PC, issues pipelined imem requests
// under a credit limit, and buffers in-order responses with their PCs for decode.
module if_prefetch_stage #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic                       clk,
  input  logic                       init,
  input  logic                       enable,
  input  logic                       redirect,
  input  logic [ADDR_W-1:0]          redirect_pc,
  output logic                       imem_req,
  output logic [ADDR_W-1:0]          imem_addr,
  input  logic                       imem_gnt,
  input  logic                       imem_rvalid,
  input  logic [DATA_W-1:0]          imem_rdata,
  output logic                       if_valid,
  output logic [ADDR_W-1:0]          if_pc,
  output logic [DATA_W-1:0]          if_instr,
  input  logic                       id_ready,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);
  localparam int unsigned ENT_W = ADDR_W + DATA_W;

  localparam logic [CNT_W-1:0]  CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  DEPTH_C    = CNT_W'(DEPTH);
  localparam logic [CNT_W:0]    DEPTH_X    = (CNT_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0]  PTR_ZERO   = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0]  PTR_ONE    = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PC_STEP    = {{(ADDR_W-3){1'b0}}, 3'b100};
  localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

  logic              run_r;
  logic [ADDR_W-1:0] fetch_pc_r;
  logic [CNT_W-1:0]  out_cnt_r;
  logic [CNT_W-1:0]  drop_cnt_r;

  logic [ADDR_W-1:0] tag_mem_r [DEPTH];
  logic [PTR_W-1:0]  tag_wr_r;
  logic [PTR_W-1:0]  tag_rd_r;

  logic [ENT_W-1:0]  fifo_mem_r [DEPTH];
  logic [PTR_W-1:0]  fifo_wr_r;
  logic [PTR_W-1:0]  fifo_rd_r;
  logic [CNT_W-1:0]  level_r;

  logic [CNT_W-1:0]  live_s;
  logic [CNT_W:0]    used_s;
  logic              req_s;
  logic              acc_s;
  logic              rsp_s;
  logic              push_s;
  logic              valid_s;
  logic              pop_s;
  logic [CNT_W-1:0]  out_next_s;
  logic [ADDR_W-1:0] redir_pc_s;
  logic [ENT_W-1:0]  head_s;
  logic [ADDR_W-1:0] head_pc_s;
  logic [DATA_W-1:0] head_instr_s;

  // Credit check, handshake qualification and head-of-FIFO view
  always_comb begin
    live_s     = out_cnt_r - drop_cnt_r;
    used_s     = {1'b0, level_r} + {1'b0, live_s};
    req_s      = run_r & enable & ~redirect & (used_s < DEPTH_X) & (out_cnt_r < DEPTH_C);
    acc_s      = req_s & imem_gnt;
    // a response with nothing outstanding can only be a stray and is ignored
    rsp_s      = imem_rvalid & (out_cnt_r != CNT_ZERO);
    push_s     = rsp_s & ~redirect & (drop_cnt_r == CNT_ZERO);
    valid_s    = enable & (level_r != CNT_ZERO);
    pop_s      = valid_s & id_ready;
    out_next_s = out_cnt_r + (acc_s ? CNT_ONE : CNT_ZERO) - (rsp_s ? CNT_ONE : CNT_ZERO);
    redir_pc_s = redirect_pc & ALIGN_MASK;
    head_s     = fifo_mem_r[fifo_rd_r];
    if (level_r != CNT_ZERO) begin
      head_pc_s    = head_s[ENT_W-1:DATA_W];
      head_instr_s = head_s[DATA_W-1:0];
    end else begin
      head_pc_s    = {ADDR_W{1'b0}};
      head_instr_s = {DATA_W{1'b0}};
    end
  end

  assign imem_req   = req_s;
  assign imem_addr  = fetch_pc_r;
  assign if_valid   = valid_s;
  assign if_pc      = head_pc_s;
  assign if_instr   = head_instr_s;
  assign fifo_level = level_r;

  // Fetch PC, outstanding-request count and stale-response drop counter
  always_ff @(posedge clk or negedge init) begin
    if (!init) begin
      run_r      <= 1'b0;
      fetch_pc_r <= RESET_PC;
      out_cnt_r  <= CNT_ZERO;
      drop_cnt_r <= CNT_ZERO;
    end else begin
      run_r     <= 1'b1;
      out_cnt_r <= out_next_s;
      if (redirect) begin
        fetch_pc_r <= redir_pc_s;
        drop_cnt_r <= out_next_s;
      end else begin
        if (acc_s) begin
          fetch_pc_r <= fetch_pc_r + PC_STEP;
        end
        if (rsp_s && (drop_cnt_r != CNT_ZERO)) begin
          drop_cnt_r <= drop_cnt_r - CNT_ONE;
        end
      end
    end
  end

  // In-order PC tag queue: written on accept, read when a live response is pushed
  always_ff @(posedge clk or negedge init) begin
    if (!init) begin
      tag_wr_r <= PTR_ZERO;
      tag_rd_r <= PTR_ZERO;
      for (int i = 0; i < int'(DEPTH); i++) begin
        tag_mem_r[i] <= {ADDR_W{1'b0}};
      end
    end else if (redirect) begin
      tag_wr_r <= PTR_ZERO;
      tag_rd_r <= PTR_ZERO;
    end else begin
      if (acc_s) begin
        tag_mem_r[tag_wr_r] <= fetch_pc_r;
        tag_wr_r            <= tag_wr_r + PTR_ONE;
      end
      if (push_s) begin
        tag_rd_r <= tag_rd_r + PTR_ONE;
      end
    end
  end

  // Prefetch FIFO of {pc, instr}; a redirect flush overrides a same-cycle pop
  always_ff @(posedge clk or negedge init) begin
    if (!init) begin
      fifo_wr_r <= PTR_ZERO;
      fifo_rd_r <= PTR_ZERO;
      level_r   <= CNT_ZERO;
      for (int i = 0; i < int'(DEPTH); i++) begin
        fifo_mem_r[i] <= {ENT_W{1'b0}};
      end
    end else if (redirect) begin
      fifo_wr_r <= PTR_ZERO;
      fifo_rd_r <= PTR_ZERO;
      level_r   <= CNT_ZERO;
    end else begin
      if (push_s) begin
        fifo_mem_r[fifo_wr_r] <= {tag_mem_r[tag_rd_r], imem_rdata};
        fifo_wr_r             <= fifo_wr_r + PTR_ONE;
      end
      if (pop_s) begin
        fifo_rd_r <= fifo_rd_r + PTR_ONE;
      end
      level_r <= level_r + (push_s ? CNT_ONE : CNT_ZERO) - (pop_s ? CNT_ONE : CNT_ZERO);
    end
  end

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Directed bench for if_prefetch_stage with an in-order, fixed-latency memory model.
module tb_if_prefetch_stage;

  logic        clk = 1'b0;
  logic        init;
  logic        enable;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        id_ready;
  logic [2:0]  fifo_level;

  int checks = 0;
  int errors = 0;
  int lat = 1;
  int cyc = 0;
  int acc_cnt = 0;
  int base;
  int waited;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;
  req_t q[$];

  logic        acc_smp = 1'b0;
  logic        rsp_smp = 1'b0;
  logic [31:0] acc_addr = 32'h0;

  always #5 clk = ~clk;

  if_prefetch_stage #(
    .ADDR_W(32), .DATA_W(32), .DEPTH(4), .RESET_PC(32'h0000_0100)
  ) dut (
    .clk(clk), .init(init), .enable(enable), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .id_ready(id_ready),
    .fifo_level(fifo_level)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hA5C3_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic edge_drv();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"},   {31'b0, imem_req}, 32'h0);
    chk({tag, "_addr"},  imem_addr, 32'h0000_0100);
    chk({tag, "_valid"}, {31'b0, if_valid}, 32'h0);
    chk({tag, "_pc"},    if_pc, 32'h0);
    chk({tag, "_instr"}, if_instr, 32'h0);
    chk({tag, "_level"}, {29'b0, fifo_level}, 32'h0);
  endtask

  task automatic restart(input int latency, input logic rdy);
    init     = 1'b0;
    redirect = 1'b0;
    enable   = 1'b1;
    id_ready = rdy;
    lat      = latency;
    @(posedge clk);
    @(posedge clk);
    #1 init = 1'b1;
  endtask

  // Memory model: sample handshakes mid-cycle, update the response queue at the edge
  always @(negedge clk) begin
    acc_smp  = imem_req & imem_gnt;
    acc_addr = imem_addr;
    rsp_smp  = imem_rvalid;
  end

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!init) begin
      q.delete();
    end else begin
      if (rsp_smp && (q.size() > 0)) q.delete(0);
      if (acc_smp) begin
        q.push_back('{acc_addr, cyc + lat - 1});
        acc_cnt = acc_cnt + 1;
      end
    end
    #1;
    if ((q.size() > 0) && (q[0].due <= cyc)) begin
      imem_rvalid = 1'b1;
      imem_rdata  = instr_of(q[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end
  end

  // A live push into a full FIFO must never happen
  always @(negedge clk) begin
    if (init && dut.push_s) begin
      chk("push_into_full", {31'b0, dut.level_r == 3'd4}, 32'h0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    init = 1'b0; enable = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
    imem_gnt = 1'b1; id_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;

    // 1: reset values, then streaming with 1-cycle memory
    @(posedge clk); #3;
    chk_reset_outputs("t1_rst");
    restart(1, 1'b1);
    edge_drv(); #1;
    chk("t1_req_c1",   {31'b0, imem_req}, 32'h1);
    chk("t1_addr_c1",  imem_addr, 32'h100);
    chk("t1_valid_c1", {31'b0, if_valid}, 32'h0);
    edge_drv(); #1;
    chk("t1_addr_c2",  imem_addr, 32'h104);
    chk("t1_valid_c2", {31'b0, if_valid}, 32'h0);
    for (int k = 3; k <= 8; k++) begin
      edge_drv(); #1;
      chk("t1_valid", {31'b0, if_valid}, 32'h1);
      chk("t1_pc",    if_pc, 32'h100 + 32'(4 * (k - 3)));
      chk("t1_instr", if_instr, instr_of(32'h100 + 32'(4 * (k - 3))));
      chk("t1_addr",  imem_addr, 32'h100 + 32'(4 * (k - 1)));
      chk("t1_level_le1", {31'b0, fifo_level <= 3'd1}, 32'h1);
    end

    // 2: decode stalled, credits cap accepted requests at DEPTH
    restart(1, 1'b0);
    base = acc_cnt;
    repeat (10) edge_drv();
    #1;
    chk("t2_accepts", 32'(acc_cnt - base), 32'd4);
    chk("t2_req",     {31'b0, imem_req}, 32'h0);
    chk("t2_level",   {29'b0, fifo_level}, 32'd4);
    chk("t2_valid",   {31'b0, if_valid}, 32'h1);
    for (int k = 0; k <= 4; k++) begin
      edge_drv();
      if (k == 0) id_ready = 1'b1;
      #1;
      chk("t2_drain_valid", {31'b0, if_valid}, 32'h1);
      chk("t2_drain_pc",    if_pc, 32'h100 + 32'(4 * k));
      if (k == 1) begin
        chk("t2_resume_req",  {31'b0, imem_req}, 32'h1);
        chk("t2_resume_addr", imem_addr, 32'h110);
      end
    end

    // 3: 3-cycle memory, redirect with 3 outstanding
    restart(3, 1'b1);
    repeat (3) edge_drv();
    #1;
    chk("t3_addr_c3", imem_addr, 32'h108);
    edge_drv();
    redirect = 1'b1; redirect_pc = 32'h0000_2002;
    #1;
    chk("t3_req_in_redirect", {31'b0, imem_req}, 32'h0);
    edge_drv();
    redirect = 1'b0;
    #1;
    chk("t3_new_req",  {31'b0, imem_req}, 32'h1);
    chk("t3_new_addr", imem_addr, 32'h2000);
    waited = 0;
    while (!if_valid && (waited < 20)) begin
      edge_drv(); #1;
      waited++;
    end
    chk("t3_wait",  32'(waited), 32'd4);
    chk("t3_pc",    if_pc, 32'h2000);
    chk("t3_instr", if_instr, instr_of(32'h2000));
    edge_drv(); #1;
    chk("t3_pc_next", if_pc, 32'h2004);

    // 4: redirect coinciding with a response and a pop
    restart(1, 1'b1);
    repeat (4) edge_drv();
    edge_drv();
    redirect = 1'b1; redirect_pc = 32'h0000_3000;
    #1;
    chk("t4_pop_valid", {31'b0, if_valid}, 32'h1);
    chk("t4_pop_pc",    if_pc, 32'h108);
    chk("t4_req",       {31'b0, imem_req}, 32'h0);
    edge_drv();
    redirect = 1'b0;
    #1;
    chk("t4_level_flushed", {29'b0, fifo_level}, 32'h0);
    chk("t4_valid_n1", {31'b0, if_valid}, 32'h0);
    chk("t4_addr_n1",  imem_addr, 32'h3000);
    edge_drv(); #1;
    chk("t4_valid_n2", {31'b0, if_valid}, 32'h0);
    edge_drv(); #1;
    chk("t4_valid_n3", {31'b0, if_valid}, 32'h1);
    chk("t4_pc_n3",    if_pc, 32'h3000);
    edge_drv(); #1;
    chk("t4_pc_n4",    if_pc, 32'h3004);

    // 5: PC wrap-around, then enable gating
    edge_drv();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    #1;
    edge_drv();
    redirect = 1'b0;
    #1;
    chk("t5_addr_top", imem_addr, 32'hFFFF_FFFC);
    edge_drv(); #1;
    chk("t5_addr_wrap", imem_addr, 32'h0);
    edge_drv(); #1;
    chk("t5_pc_top",  if_pc, 32'hFFFF_FFFC);
    edge_drv(); #1;
    chk("t5_pc_wrap", if_pc, 32'h0);
    chk("t5_instr_wrap", if_instr, instr_of(32'h0));
    edge_drv();
    enable = 1'b0;
    #1;
    chk("t5_dis_valid", {31'b0, if_valid}, 32'h0);
    chk("t5_dis_req",   {31'b0, imem_req}, 32'h0);
    edge_drv();
    enable = 1'b1;
    #1;
    chk("t5_en_pc",    if_pc, 32'h4);
    chk("t5_en_level", {29'b0, fifo_level}, 32'd2);

    // 6: asynchronous reset mid-stream
    restart(3, 1'b0);
    repeat (7) edge_drv();
    #1;
    chk("t6_level_before", {29'b0, fifo_level}, 32'd3);
    init = 1'b0;
    #1;
    chk_reset_outputs("t6_rst");
    lat = 1;
    id_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 init = 1'b1;
    edge_drv(); #1;
    chk("t6_req",  {31'b0, imem_req}, 32'h1);
    chk("t6_addr", imem_addr, 32'h100);
    edge_drv(); #1;
    chk("t6_valid_c2", {31'b0, if_valid}, 32'h0);
    edge_drv(); #1;
    chk("t6_valid_c3", {31'b0, if_valid}, 32'h1);
    chk("t6_pc_c3",    if_pc, 32'h100);
    edge_drv(); #1;
    chk("t6_pc_c4",    if_pc, 32'h104);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
